ras_spill_responder: RTL
========================

# ras_spill_responder

Memory-side responder for the encrypted return-address-stack spill port, sitting on the MMIO bus opposite the RAS controller. It services the controller's spill reads and writes of ciphertext words from a private single-port word store, and forwards CPU MMIO writes into the controller's configuration port (enable, spill base, key words). It also gives the CPU a debug window into the spill store, a status/error register and a high-water counter.

## Interface
Parameters:
- W, 32: data word width.
- DEPTH, 1024: spill store depth in words (power of two).
- SPILL_OFF, 32'h1000: MMIO byte offset of the spill debug window.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ras_mem_rd  in  1  controller read strobe; one word per cycle.
- ras_mem_wr  in  1  controller write strobe.
- ras_mem_addr  in  32  byte address, word aligned; includes controller base.
- ras_mem_din  in  W  write data.
- ras_mem_dout  out  W  read data.
- ras_mem_rdy  out  1  port free; the controller issues only while high.
- mmio_addr  in  16  CPU byte offset within this block.
- mmio_rd, mmio_wr  in  1  CPU request; held until ack.
- mmio_din  in  32  CPU write data.
- mmio_dout  out  32  CPU read data, valid while mmio_ack is high.
- mmio_ack  out  1  one-cycle completion pulse.
- config_addr  out  3  controller config register index.
- config_din  out  32  config data.
- config_wr  out  1  one-cycle config write pulse.
- err  out  1  sticky out-of-range flag.

## Operation
- Spill index is (ras_mem_addr − base_shadow) >> 2. An address is in range when ras_mem_addr ≥ base_shadow and the index < DEPTH.
- In-range write stores ras_mem_din. Out-of-range write is dropped and sets err.
- In-range read returns the stored word. Out-of-range read returns 0 and sets err.
- If ras_mem_rd and ras_mem_wr are both high, the write wins and ras_mem_dout holds its previous value.
- MMIO map (word offsets):
  - 0x00–0x1C: config. A write emits config_wr with config_addr = mmio_addr[4:2] and config_din = mmio_din, and updates a shadow register. A read returns the shadow.
  - Shadow reset values: ena = 1, base = 0, key[0..3] = 32'hdeadbeef. Indices 2 and 3 are not shadowed and read as 0.
  - 0x20: status. Bit 0 is err; writing 1 to bit 0 clears it.
  - 0x24: high-water mark, the maximum in-range write index + 1. Any write to 0x24 clears it.
  - SPILL_OFF + 4·i: CPU access to store word i. An index ≥ DEPTH acks, reads 0 and sets err.
  - Other offsets: writes are ignored, reads return 0, and the access still acks.
- If mmio_rd and mmio_wr are both high, the access is a write.
- Arbiter FSM:
  - IDLE: an MMIO request to a register completes via REG_ACK; a request to the spill window goes to CPU_GRANT.
  - CPU_GRANT: ras_mem_rdy is low and the store is accessed by the CPU. Next state is CPU_ACK.
  - CPU_ACK: mmio_ack is high. Next state is IDLE.
  - REG_ACK: mmio_ack is high. Next state is IDLE.
  - MMIO requests are not re-sampled until the FSM is back in IDLE.

## Timing
- Reset values: ras_mem_rdy = 1, ras_mem_dout = 0, mmio_ack = 0, mmio_dout = 0, config_wr = 0, err = 0, high-water = 0, FSM = IDLE. Store contents are not cleared.
- Controller read issued in cycle T: ras_mem_dout is valid in T+1 and holds until the next controller read. Back-to-back reads pipeline at one per cycle.
- CPU accesses never alter ras_mem_dout.
- ras_mem_rdy is registered and never depends on the current controller strobes.
- Spill-window request sampled in IDLE at cycle T:
  - ras_mem_rdy = 0 in T+1 (CPU_GRANT).
  - mmio_ack = 1 in T+2, with read data on mmio_dout.
  - A controller access in T is still served in T.
- Register request sampled at T: mmio_ack in T+1. For config writes, config_wr pulses in T+1.
- Config write to base: the new base applies to controller accesses from T+2 on.
- err set and a status clear in the same cycle: the set wins.
- rst asserted mid-access: the access is aborted, no ack is issued, and outputs return to reset values in the next cycle.

## Test plan
- Controller writes 0xA5A5_0001 to base+0 and 0x5A5A_0002 to base+4, then reads base+4 and base+0 back-to-back → ras_mem_dout = 0x5A5A_0002 in the cycle after the first read and 0xA5A5_0001 one cycle later.
- MMIO write of 0x0000_2000 to offset 0x04 → config_wr pulses one cycle later with config_addr = 1 and config_din = 0x2000. A controller write to 0x2008 then lands in index 2, which an MMIO read of SPILL_OFF+8 returns.
- Controller write to base + 4·DEPTH → store unchanged and err = 1. Reading 0x20 returns 1; writing 1 to 0x20 then clears it to 0.
- MMIO read of the spill window in the same cycle as a controller write → controller write served that cycle, ras_mem_rdy = 0 for exactly one cycle, mmio_ack two cycles later with the stored data.
- Controller writes to indices 0..5 → 0x24 reads 6. Writing 0x24 then reads 0.
- rst asserted in CPU_GRANT → no mmio_ack, ras_mem_rdy = 1 afterwards, and all config shadows return to their reset values.

Source files
------------

// File: rtl/ras_spill_responder.sv
// Memory-side responder for the encrypted RAS spill port.
// It serves controller spill reads and writes from a private word store, and
// forwards CPU MMIO config writes to the controller while keeping a local
// shadow of them. It also gives the CPU a debug window into the store, a
// sticky error flag and a high-water mark of controller spill writes.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | store owned by controller, MMIO requests sampled here
// CPU_GRANT | ras_mem_rdy low, CPU reads/writes the store this cycle
// CPU_ACK   | spill-window access complete, mmio_ack high
// REG_ACK   | register access complete, mmio_ack high
module ras_spill_responder #(
    parameter int          W         = 32,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] SPILL_OFF = 32'h1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ras_mem_rd,
    input  logic          ras_mem_wr,
    input  logic [31:0]   ras_mem_addr,
    input  logic [W-1:0]  ras_mem_din,
    output logic [W-1:0]  ras_mem_dout,
    output logic          ras_mem_rdy,
    input  logic [15:0]   mmio_addr,
    input  logic          mmio_rd,
    input  logic          mmio_wr,
    input  logic [31:0]   mmio_din,
    output logic [31:0]   mmio_dout,
    output logic          mmio_ack,
    output logic [2:0]    config_addr,
    output logic [31:0]   config_din,
    output logic          config_wr,
    output logic          err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CPU_GRANT, CPU_ACK, REG_ACK} state_t;

    state_t state, state_nxt;

    logic [W-1:0]  mem [DEPTH];

    // config shadows; indices 2 and 3 have no shadow
    logic [31:0]   ena_q;
    logic [31:0]   base_q;
    logic [31:0]   key_q [4];

    logic [AW:0]   hwm_q, hwm_nxt;

    // CPU spill-window request latched when it leaves IDLE
    logic          cpu_wr_q;
    logic          cpu_ok_q;
    logic [AW-1:0] cpu_idx_q;
    logic [W-1:0]  cpu_din_q;

    logic          mmio_req, take, is_spill, is_cfg, is_status, is_hwm;
    logic [29:0]   spill_word, ctrl_word;
    logic          ctrl_in, ctrl_wr, ctrl_rd, cpu_act;
    logic [AW-1:0] port_idx;
    logic          mem_we;
    logic [W-1:0]  mem_wdata, rd_word;
    logic [31:0]   reg_rdata;
    logic          err_set, err_clr, hwm_clr;

    assign mmio_req   = mmio_rd | mmio_wr;
    assign take       = (state == IDLE) && mmio_req;
    assign is_spill   = {16'h0, mmio_addr} >= SPILL_OFF;
    assign is_cfg     = !is_spill && (mmio_addr < 16'h0020);
    assign is_status  = !is_spill && (mmio_addr == 16'h0020);
    assign is_hwm     = !is_spill && (mmio_addr == 16'h0024);
    assign spill_word = 30'(({16'h0, mmio_addr} - SPILL_OFF) >> 2);

    // Controller strobes are only honoured while the port is advertised free.
    assign ctrl_word  = 30'((ras_mem_addr - base_q) >> 2);
    assign ctrl_in    = (ras_mem_addr >= base_q) && (ctrl_word[29:AW] == '0);
    assign ctrl_wr    = ras_mem_wr & ras_mem_rdy;
    assign ctrl_rd    = ras_mem_rd & ~ras_mem_wr & ras_mem_rdy;
    assign cpu_act    = (state == CPU_GRANT);

    // Single store port: the CPU owns it in CPU_GRANT, the controller otherwise.
    assign port_idx   = cpu_act ? cpu_idx_q : ctrl_word[AW-1:0];
    assign mem_we     = !rst && (cpu_act ? (cpu_wr_q && cpu_ok_q) : (ctrl_wr && ctrl_in));
    assign mem_wdata  = cpu_act ? cpu_din_q : ras_mem_din;
    assign rd_word    = mem[port_idx];

    assign err_set    = (!cpu_act && (ras_mem_rd | ras_mem_wr) && ras_mem_rdy && !ctrl_in)
                     || (cpu_act && !cpu_ok_q);
    assign err_clr    = take && mmio_wr && is_status && mmio_din[0];
    assign hwm_clr    = take && mmio_wr && is_hwm;

    // Next-state and ack decode for the MMIO/controller arbiter.
    always_comb begin
        state_nxt = state;
        mmio_ack  = 1'b0;
        case (state)
            IDLE:      if (mmio_req) state_nxt = is_spill ? CPU_GRANT : REG_ACK;
            CPU_GRANT: state_nxt = CPU_ACK;
            CPU_ACK: begin
                mmio_ack  = 1'b1;
                state_nxt = IDLE;
            end
            REG_ACK: begin
                mmio_ack  = 1'b1;
                state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // Register-space read data.
    always_comb begin
        reg_rdata = 32'h0;
        if (is_cfg) begin
            case (mmio_addr[4:2])
                3'd0:    reg_rdata = ena_q;
                3'd1:    reg_rdata = base_q;
                3'd4:    reg_rdata = key_q[0];
                3'd5:    reg_rdata = key_q[1];
                3'd6:    reg_rdata = key_q[2];
                3'd7:    reg_rdata = key_q[3];
                default: reg_rdata = 32'h0;
            endcase
        end else if (is_status) begin
            reg_rdata = {31'h0, err};
        end else if (is_hwm) begin
            reg_rdata = 32'(hwm_q);
        end
    end

    // High-water update; a same-cycle spill write survives a clear.
    always_comb begin
        hwm_nxt = hwm_clr ? '0 : hwm_q;
        if (ctrl_wr && ctrl_in && ({1'b0, ctrl_word[AW-1:0]} + 1'b1) > hwm_nxt)
            hwm_nxt = {1'b0, ctrl_word[AW-1:0]} + 1'b1;
    end

    // Store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[port_idx] <= mem_wdata;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath registers: port outputs, shadows, flags and latched CPU request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_mem_dout <= '0;
            ras_mem_rdy  <= 1'b1;
            mmio_dout    <= 32'h0;
            config_addr  <= 3'd0;
            config_din   <= 32'h0;
            config_wr    <= 1'b0;
            err          <= 1'b0;
            hwm_q        <= '0;
            ena_q        <= 32'h1;
            base_q       <= 32'h0;
            for (int i = 0; i < 4; i++) key_q[i] <= 32'hdeadbeef;
            cpu_wr_q     <= 1'b0;
            cpu_ok_q     <= 1'b0;
            cpu_idx_q    <= '0;
            cpu_din_q    <= '0;
        end else begin
            ras_mem_rdy <= (state_nxt != CPU_GRANT);
            config_wr   <= 1'b0;
            mmio_dout   <= 32'h0;
            hwm_q       <= hwm_nxt;

            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;

            if (take && !is_spill) begin
                if (mmio_wr) begin
                    if (is_cfg) begin
                        config_wr   <= 1'b1;
                        config_addr <= mmio_addr[4:2];
                        config_din  <= mmio_din;
                    end
                end else begin
                    mmio_dout <= reg_rdata;
                end
            end

            if (take && is_spill) begin
                cpu_wr_q  <= mmio_wr;
                cpu_ok_q  <= (spill_word[29:AW] == '0);
                cpu_idx_q <= spill_word[AW-1:0];
                cpu_din_q <= W'(mmio_din);
            end

            if (cpu_act && !cpu_wr_q)
                mmio_dout <= cpu_ok_q ? 32'(rd_word) : 32'h0;

            // Shadows follow the forwarded pulse so the controller and the
            // local base switch over together.
            if (config_wr) begin
                case (config_addr)
                    3'd0:    ena_q  <= config_din;
                    3'd1:    base_q <= config_din;
                    3'd4:    key_q[0] <= config_din;
                    3'd5:    key_q[1] <= config_din;
                    3'd6:    key_q[2] <= config_din;
                    3'd7:    key_q[3] <= config_din;
                    default: ;
                endcase
            end

            if (ctrl_rd)
                ras_mem_dout <= ctrl_in ? rd_word : '0;
        end
    end

endmodule
